// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: synchronous data-memory port between the MEM stage and the data RAM.
// Ports: dmem_en read/write strobe, dmem_addr word-aligned address, dmem_wdata lane-replicated
//   store data, dmem_be byte write enables (stage -> RAM); dmem_rdata registered read word (RAM -> stage).
// Modports: master = pipeline stage, slave = RAM.
interface mem_wb_stage_if;
  logic        dmem_en;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  modport master (output dmem_en, dmem_addr, dmem_wdata, dmem_be, input dmem_rdata);
  modport slave  (input dmem_en, dmem_addr, dmem_wdata, dmem_be, output dmem_rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM and MEM/WB pipeline registers, data-memory port, load extract and writeback select.
// Ports: clk, rst_n (synchronous active-low); stall, flush_ex hazard controls; *_ex EX-stage fields;
//   ALUResult_mem/rdAddr_mem/RegWrite_mem/MemRead_mem EX/MEM forward sources; dmem data-RAM port
//   (mem_wb_stage_if.master); RegWriteData_wb/rdAddr_wb/RegWrite_wb MEM/WB forward and register-file
//   write; misalign_err trap pulse aligned with WB.
// Optional: define MEM_MISALIGN_TRAP_EN to suppress and flag misaligned half/word accesses;
//   otherwise low address bits below the access size are ignored and misalign_err stays 0.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush_ex,
  input  logic [DATA_W-1:0] ALUResult_ex,
  input  logic [DATA_W-1:0] MemWriteData_ex,
  input  logic [4:0]        rdAddr_ex,
  input  logic              RegWrite_ex,
  input  logic              MemRead_ex,
  input  logic              MemWrite_ex,
  input  logic              MemtoReg_ex,
  input  logic [2:0]        funct3_ex,
  output logic [DATA_W-1:0] ALUResult_mem,
  output logic [4:0]        rdAddr_mem,
  output logic              RegWrite_mem,
  output logic              MemRead_mem,
  mem_wb_stage_if.master    dmem,
  output logic [DATA_W-1:0] RegWriteData_wb,
  output logic [4:0]        rdAddr_wb,
  output logic              RegWrite_wb,
  output logic              misalign_err
);
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wd;
    logic [4:0]        rd;
    logic              rw;
    logic              mr;
    logic              mw;
    logic              m2r;
    logic [2:0]        f3;
  } exm_t;
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [4:0]        rd;
    logic              rw;
    logic              m2r;
    logic              err;
    logic [2:0]        f3;
  } mwb_t;
  exm_t              exm_q, exm_d, cap_m;
  mwb_t              mwb_q, mwb_d, cap_w;
  logic              mis;
  logic [3:0]        be_v;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] ld_v;
  always_ff @(posedge clk) begin
    exm_q <= exm_d;
    mwb_q <= mwb_d;
  end
  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    // f3[1:0]==01 covers LH/LHU/SH; 010 is LW/SW
    mis = (exm_q.mr | exm_q.mw) &
          (((exm_q.f3[1:0] == 2'b01) & exm_q.alu[0]) | ((exm_q.f3 == 3'b010) & (|exm_q.alu[1:0])));
`else
    mis = 1'b0;
`endif
    cap_m = '{alu: ALUResult_ex, wd: MemWriteData_ex, rd: rdAddr_ex,
              rw: RegWrite_ex & ~(ZERO_GUARD & (rdAddr_ex == 5'd0)),
              mr: MemRead_ex, mw: MemWrite_ex, m2r: MemtoReg_ex, f3: funct3_ex};
    cap_w = '{alu: exm_q.alu, rd: exm_q.rd, rw: exm_q.rw & ~mis, m2r: exm_q.m2r, err: mis, f3: exm_q.f3};
    exm_d = !rst_n ? '0 : stall ? exm_q : flush_ex ? '0 : cap_m;
    mwb_d = !rst_n ? '0 : stall ? mwb_q : cap_w;
  end
  always_comb begin
    be_v = exm_q.f3 == 3'b000 ? 4'b0001 << exm_q.alu[1:0] :
           exm_q.f3 == 3'b001 ? (exm_q.alu[1] ? 4'b1100 : 4'b0011) :
           exm_q.f3 == 3'b010 ? 4'b1111 : 4'b0000;
    // stall drops the strobe so the RAM output register, and hence RegWriteData_wb, holds
    dmem.dmem_en    = ~stall & (exm_q.mr | exm_q.mw) & ~mis;
    dmem.dmem_be    = (exm_q.mw & ~mis) ? be_v : 4'b0000;
    dmem.dmem_addr  = {exm_q.alu[DATA_W-1:2], 2'b00};
    dmem.dmem_wdata = exm_q.f3 == 3'b000 ? {4{exm_q.wd[7:0]}} :
                      exm_q.f3 == 3'b001 ? {2{exm_q.wd[15:0]}} : exm_q.wd;
    byte_v = 8'(dmem.dmem_rdata >> {mwb_q.alu[1:0], 3'b000});
    half_v = mwb_q.alu[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    ld_v   = mwb_q.f3 == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
             mwb_q.f3 == 3'b100 ? {24'd0, byte_v} :
             mwb_q.f3 == 3'b001 ? {{16{half_v[15]}}, half_v} :
             mwb_q.f3 == 3'b101 ? {16'd0, half_v} : dmem.dmem_rdata;
    ALUResult_mem   = exm_q.alu;
    rdAddr_mem      = exm_q.rd;
    RegWrite_mem    = exm_q.rw;
    MemRead_mem     = exm_q.mr;
    RegWriteData_wb = mwb_q.m2r ? ld_v : mwb_q.alu;
    rdAddr_wb       = mwb_q.rd;
    RegWrite_wb     = mwb_q.rw;
    misalign_err    = mwb_q.err;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table, hand sequences and randomized traffic against a transaction-level model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, stall, flush_ex, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex;
  logic [31:0] ALUResult_ex, MemWriteData_ex, ALUResult_mem, RegWriteData_wb;
  logic [4:0]  rdAddr_ex, rdAddr_mem, rdAddr_wb;
  logic [2:0]  funct3_ex;
  logic        RegWrite_mem, MemRead_mem, RegWrite_wb, misalign_err;
  mem_wb_stage_if dmem ();
  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_ex(flush_ex),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex), .rdAddr_ex(rdAddr_ex),
    .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .MemWrite_ex(MemWrite_ex),
    .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem),
    .MemRead_mem(MemRead_mem), .dmem(dmem),
    .RegWriteData_wb(RegWriteData_wb), .rdAddr_wb(rdAddr_wb), .RegWrite_wb(RegWrite_wb),
    .misalign_err(misalign_err)
  );
  logic [31:0] ram [16] = '{default: 32'h0};
  logic [31:0] rdata_q = 32'h0;
  assign dmem.dmem_rdata = rdata_q;
  always @(posedge clk) if (dmem.dmem_en) begin
    for (int b = 0; b < 4; b++) if (dmem.dmem_be[b]) ram[dmem.dmem_addr[5:2]][b*8 +: 8] <= dmem.dmem_wdata[b*8 +: 8];
    rdata_q <= ram[dmem.dmem_addr[5:2]];
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct packed {
    logic [31:0] a, d;
    logic [4:0]  rd;
    logic        rw, ld, st;
    logic [2:0]  f3;
  } ins_t;
  function automatic bit f_mis(ins_t i);
`ifdef MEM_MISALIGN_TRAP_EN
    return (i.ld || i.st) && (((i.f3 == 1 || i.f3 == 5) && i.a % 2 != 0) || (i.f3 == 2 && i.a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [3:0] f_be(ins_t i);
    if (!i.st || f_mis(i)) return 4'h0;
    case (i.f3)
      3'd0: return 4'(1 << (i.a % 4));
      3'd1: return (i.a % 4 < 2) ? 4'h3 : 4'hC;
      3'd2: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction
  function automatic logic [31:0] f_wd(ins_t i);
    case (i.f3)
      3'd0: return {24'd0, i.d[7:0]} * 32'h01010101;
      3'd1: return {16'd0, i.d[15:0]} * 32'h00010001;
      default: return i.d;
    endcase
  endfunction
  function automatic logic [31:0] f_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [31:0] b = (w >> (8 * (a % 4))) & 32'hFF;
    logic [31:0] h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0: return b > 127 ? b - 256 : b;
      3'd4: return b;
      3'd1: return h > 32767 ? h - 65536 : h;
      3'd5: return h;
      default: return w;
    endcase
  endfunction
  ins_t        m_mem = '0, m_wb = '0;
  bit          m_bad = 1'b0, chk_en = 1'b0;
  logic [31:0] m_word = 32'h0;
  logic [31:0] mmem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    ins_t nx;
    logic [3:0] be;
    logic [31:0] wd;
    be = f_be(m_mem);
    wd = f_wd(m_mem);
    if (!stall) begin
      for (int b = 0; b < 4; b++) if (be[b]) mmem[m_mem.a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
      if (m_mem.ld && !f_mis(m_mem)) m_word = mmem[m_mem.a[5:2]];
    end
    nx = '{a: ALUResult_ex, d: MemWriteData_ex, rd: rdAddr_ex, rw: RegWrite_ex && rdAddr_ex != 0,
           ld: MemRead_ex, st: MemWrite_ex, f3: funct3_ex};
    if (!rst_n) begin
      m_mem = '0;
      m_wb = '0;
      m_bad = 1'b0;
    end else if (!stall) begin
      m_wb = m_mem;
      m_bad = f_mis(m_mem);
      m_mem = flush_ex ? '0 : nx;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("m_alu_mem", ALUResult_mem, m_mem.a);
    chk("m_rd_mem", rdAddr_mem, m_mem.rd);
    chk("m_rw_mem", RegWrite_mem, m_mem.rw);
    chk("m_mr_mem", MemRead_mem, m_mem.ld);
    chk("m_en", dmem.dmem_en, !stall && (m_mem.ld || m_mem.st) && !f_mis(m_mem));
    chk("m_be", dmem.dmem_be, f_be(m_mem));
    chk("m_addr", dmem.dmem_addr, m_mem.a & ~32'd3);
    if (m_mem.st) chk("m_wdata", dmem.dmem_wdata, f_wd(m_mem));
    chk("m_rd_wb", rdAddr_wb, m_wb.rd);
    chk("m_rw_wb", RegWrite_wb, m_wb.rw && !m_bad);
    if (!m_wb.ld) chk("m_wbdata_alu", RegWriteData_wb, m_wb.a);
    else if (!m_bad) chk("m_wbdata_ld", RegWriteData_wb, f_load(m_wb.f3, m_wb.a, m_word));
    chk("m_err", misalign_err, m_bad);
  end
  task automatic drive(bit ld, bit st, bit alu, logic [2:0] f3, logic [31:0] a, logic [31:0] d, logic [4:0] rd);
    ALUResult_ex = a;
    MemWriteData_ex = d;
    rdAddr_ex = rd;
    MemRead_ex = ld;
    MemtoReg_ex = ld;
    MemWrite_ex = st;
    RegWrite_ex = ld | alu;
    funct3_ex = f3;
  endtask
  typedef struct {
    bit ld, st, alu;
    logic [2:0] f3;
    logic [31:0] a, d;
    logic [4:0] rd;
    logic [3:0] be;
    logic [31:0] wd, wb;
    bit rwm, err;
  } vec_t;
  function automatic vec_t mk(bit ld, bit st, bit alu, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                              logic [4:0] rd, logic [3:0] be, logic [31:0] wd, logic [31:0] wb, bit rwm, bit err);
    vec_t v;
    v = '{ld: ld, st: st, alu: alu, f3: f3, a: a, d: d, rd: rd, be: be, wd: wd, wb: wb, rwm: rwm, err: err};
    return v;
  endfunction
`ifdef MEM_MISALIGN_TRAP_EN
  localparam logic [31:0] W_LAST = 32'hBEEF7FFF;
`else
  localparam logic [31:0] W_LAST = 32'h11223344;
`endif
  vec_t vt[$];
  vec_t v;
  int k;
  logic [2:0] f3r;
  initial begin
    vt.push_back(mk(0, 1, 0, 3'd2, 32'h100, 32'h80017FFF, 5'd0, 4'hF, 32'h80017FFF, 32'h100, 0, 0));
    vt.push_back(mk(1, 0, 0, 3'd1, 32'h102, 32'h0, 5'd6, 4'h0, 32'h0, 32'hFFFF8001, 1, 0));
    vt.push_back(mk(1, 0, 0, 3'd5, 32'h102, 32'h0, 5'd7, 4'h0, 32'h0, 32'h00008001, 1, 0));
    vt.push_back(mk(0, 1, 0, 3'd0, 32'h103, 32'hA5, 5'd0, 4'h8, 32'hA5A5A5A5, 32'h103, 0, 0));
    vt.push_back(mk(1, 0, 0, 3'd0, 32'h103, 32'h0, 5'd8, 4'h0, 32'h0, 32'hFFFFFFA5, 1, 0));
    vt.push_back(mk(1, 0, 0, 3'd4, 32'h103, 32'h0, 5'd9, 4'h0, 32'h0, 32'h000000A5, 1, 0));
    vt.push_back(mk(1, 0, 0, 3'd2, 32'h100, 32'h0, 5'd10, 4'h0, 32'h0, 32'hA5017FFF, 1, 0));
    vt.push_back(mk(1, 0, 0, 3'd0, 32'h101, 32'h0, 5'd11, 4'h0, 32'h0, 32'h0000007F, 1, 0));
    vt.push_back(mk(1, 0, 0, 3'd1, 32'h100, 32'h0, 5'd12, 4'h0, 32'h0, 32'h00007FFF, 1, 0));
    vt.push_back(mk(0, 0, 1, 3'd0, 32'h1234, 32'h0, 5'd5, 4'h0, 32'h0, 32'h1234, 1, 0));
    vt.push_back(mk(0, 0, 1, 3'd0, 32'h55, 32'h0, 5'd0, 4'h0, 32'h0, 32'h55, 0, 0));
    vt.push_back(mk(0, 1, 0, 3'd1, 32'h102, 32'h1234BEEF, 5'd0, 4'hC, 32'hBEEFBEEF, 32'h102, 0, 0));
    vt.push_back(mk(1, 0, 0, 3'd3, 32'h100, 32'h0, 5'd13, 4'h0, 32'h0, 32'hBEEF7FFF, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
    vt.push_back(mk(0, 1, 0, 3'd2, 32'h102, 32'h11223344, 5'd0, 4'h0, 32'h11223344, 32'h102, 0, 1));
`else
    vt.push_back(mk(0, 1, 0, 3'd2, 32'h102, 32'h11223344, 5'd0, 4'hF, 32'h11223344, 32'h102, 0, 0));
`endif
    vt.push_back(mk(1, 0, 0, 3'd2, 32'h100, 32'h0, 5'd14, 4'h0, 32'h0, W_LAST, 1, 0));
    // reset for two cycles; the first with stall so no stray RAM strobe from power-up state
    rst_n = 1'b0;
    stall = 1'b1;
    flush_ex = 1'b0;
    drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
    @(posedge clk); #1;
    chk_en = 1'b1;
    stall = 1'($urandom);
    flush_ex = 1'($urandom);
    drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
    @(posedge clk); #1;
    rst_n = 1'b1;
    stall = 1'b0;
    flush_ex = 1'b0;
    drive(0, 0, 1, 3'd0, 32'hCAFE, 32'h0, 5'd2);
    @(negedge clk);
    chk("rst_alu_mem", ALUResult_mem, 0);
    chk("rst_rd_mem", rdAddr_mem, 0);
    chk("rst_rw_mem", RegWrite_mem, 0);
    chk("rst_mr_mem", MemRead_mem, 0);
    chk("rst_en", dmem.dmem_en, 0);
    chk("rst_be", dmem.dmem_be, 0);
    chk("rst_addr", dmem.dmem_addr, 0);
    chk("rst_wbdata", RegWriteData_wb, 0);
    chk("rst_rd_wb", rdAddr_wb, 0);
    chk("rst_rw_wb", RegWrite_wb, 0);
    chk("rst_err", misalign_err, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    chk("first_alu_mem", ALUResult_mem, 32'hCAFE);
    chk("first_rd_mem", rdAddr_mem, 5'd2);
    chk("first_rw_mem", RegWrite_mem, 1);
    for (int i = 0; i < vt.size() + 2; i++) begin
      @(posedge clk); #1;
      if (i < vt.size()) drive(vt[i].ld, vt[i].st, vt[i].alu, vt[i].f3, vt[i].a, vt[i].d, vt[i].rd);
      else drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      if (i >= 1) begin
        v = vt[i-1];
        chk("tbl_alu_mem", ALUResult_mem, v.a);
        chk("tbl_rw_mem", RegWrite_mem, v.rwm);
        chk("tbl_be", dmem.dmem_be, v.be);
        chk("tbl_addr", dmem.dmem_addr, {v.a[31:2], 2'b00});
        if (v.st) chk("tbl_wdata", dmem.dmem_wdata, v.wd);
      end
      if (i >= 2) begin
        v = vt[i-2];
        chk("tbl_wbdata", RegWriteData_wb, v.wb);
        chk("tbl_rw_wb", RegWrite_wb, v.rwm && !v.err);
        chk("tbl_err", misalign_err, v.err);
      end
    end
    // load stalled three cycles in MEM, then released into WB
    @(posedge clk); #1;
    drive(1, 0, 0, 3'd2, 32'h100, 32'h0, 5'd3);
    @(posedge clk); #1;
    drive(0, 0, 1, 3'd0, 32'h77, 32'h0, 5'd4);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stl_alu_mem", ALUResult_mem, 32'h100);
      chk("stl_rd_mem", rdAddr_mem, 5'd3);
      chk("stl_en", dmem.dmem_en, 0);
      chk("stl_rw_wb", RegWrite_wb, 0);
      @(posedge clk);
    end
    #1 stall = 1'b0;
    @(negedge clk);
    chk("stl_en_rel", dmem.dmem_en, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    chk("stl_rd_wb", rdAddr_wb, 5'd3);
    chk("stl_rw_wb_rel", RegWrite_wb, 1);
    chk("stl_wbdata", RegWriteData_wb, W_LAST);
    chk("stl_next_mem", ALUResult_mem, 32'h77);
    // flushed ALU op becomes a bubble
    @(posedge clk); #1;
    drive(0, 0, 1, 3'd0, 32'h99, 32'h0, 5'd9);
    flush_ex = 1'b1;
    @(posedge clk); #1;
    flush_ex = 1'b0;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    chk("fl_rw_mem", RegWrite_mem, 0);
    chk("fl_alu_mem", ALUResult_mem, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl_rw_wb", RegWrite_wb, 0);
    chk("fl_rd_wb", rdAddr_wb, 0);
    repeat (600) begin
      @(posedge clk); #1;
      rst_n = $urandom_range(0, 39) != 0;
      stall = $urandom_range(0, 4) == 0;
      flush_ex = $urandom_range(0, 5) == 0;
      k = $urandom_range(0, 3);
      f3r = k == 1 ? 3'($urandom_range(0, 7)) : k == 2 ? 3'($urandom_range(0, 2)) : 3'($urandom);
      drive(k == 1, k == 2, k == 3, f3r, 32'($urandom_range(0, 63)), $urandom, 5'($urandom_range(0, 31)));
    end
    @(posedge clk); #1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Producer side of the EX-stage operand-forwarding interface.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the synchronous data-memory port.
- Performs load sign/zero extension and the writeback select.
- Generates ALUResult_mem, rdAddr_mem, RegWrite_mem, RegWriteData_wb, rdAddr_wb and RegWrite_wb, which feed the EX forwarding muxes and the register file.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
ZERO_GUARD, 1, when 1, any instruction with rd=x0 has RegWrite cleared on capture into EX/MEM.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  freeze both pipeline registers and the memory port
flush_ex  input  1  insert a bubble into EX/MEM instead of the EX instruction
ALUResult_ex  input  32  ALU result / effective address
MemWriteData_ex  input  32  forwarded store data
rdAddr_ex  input  5  destination register
RegWrite_ex  input  1  writes register file
MemRead_ex  input  1  load
MemWrite_ex  input  1  store
MemtoReg_ex  input  1  writeback from memory
funct3_ex  input  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ALUResult_mem  output  32  EX/MEM result, forward source
rdAddr_mem  output  5  EX/MEM rd
RegWrite_mem  output  1  EX/MEM write enable
MemRead_mem  output  1  load in MEM, for the load-use hazard unit
dmem_en  output  1  memory enable (read/write strobe)
dmem_addr  output  32  {ALUResult_mem[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte write enables
dmem_rdata  input  32  read word, valid one cycle after dmem_en with MemRead
RegWriteData_wb  output  32  writeback value, forward source
rdAddr_wb  output  5  MEM/WB rd
RegWrite_wb  output  1  MEM/WB write enable
misalign_err  output  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (rst_n=0 at posedge):
  - All EX/MEM and MEM/WB fields clear to 0.
  - All outputs read 0, including RegWriteData_wb, dmem_be and dmem_en.
  - Reset overrides stall and flush.
- Priority at each posedge: reset > stall > flush_ex > capture.
- Stall:
  - Both registers hold their values.
  - dmem_en=0, so the RAM output register holds and RegWriteData_wb stays stable.
  - No store is issued during a stall.
- flush_ex: EX/MEM loads RegWrite=MemRead=MemWrite=MemtoReg=0. The other fields are don't-care but are cleared to 0.
- Capture: EX/MEM takes the EX inputs. With ZERO_GUARD=1 and rdAddr_ex=0, RegWrite_mem=0.
- MEM/WB always captures EX/MEM (rd, RegWrite, MemtoReg, funct3, ALUResult[1:0], ALUResult) unless stalled.
- Latency: an EX result appears on *_mem 1 cycle later and on *_wb 2 cycles later. Load data is on RegWriteData_wb in the cycle after MEM.
- dmem_en = !stall & (MemRead_mem | MemWrite_mem).
- dmem_be, only when MemWrite_mem, else 0:
  - SB: 1<<a[1:0]
  - SH: 0011 if a[1]=0, else 1100
  - SW: 1111
- dmem_wdata: SB replicates byte 4x; SH replicates half 2x; SW passes the word through.
- Load extract in WB, using the registered a[1:0] and funct3:
  - LB/LBU select byte a[1:0]; LH/LHU select half a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - An unlisted funct3 yields a zero-extended word.
- RegWriteData_wb = MemtoReg_wb ? extracted load : ALUResult_wb.
- Back-to-back store then load to the same address: the RAM handles read-after-write ordering. The block adds no bypass.
- Flush and stall together: stall wins; the flush is lost and the hazard unit must reassert it.

Optional Feature:
Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access in MEM (LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]≠0) forces dmem_be=0 and dmem_en=0.
  - The MEM/WB capture clears RegWrite.
  - misalign_err is a registered 1-cycle pulse aligned with WB.
- Undefined:
  - Low address bits below the access size are ignored: a half-word uses a[1], a word is forced aligned.
  - misalign_err=0.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs → all outputs 0; release → first EX instruction appears on _mem next cycle.
- ALU pipeline: ADD result 0x1234 to rd=5, RegWrite=1 → cycle+1 ALUResult_mem=0x1234, rdAddr_mem=5; cycle+2 RegWriteData_wb=0x1234, RegWrite_wb=1; rd=0 → RegWrite_mem=0.
- Store/load: SB 0xA5 to 0x103 → dmem_be=1000, wdata=0xA5A5A5A5. LB from 0x103 with rdata=0xA5000000 → RegWriteData_wb=0xFFFFFFA5; LBU → 0x000000A5.
- Half load: LH from 0x102 with rdata=0x8001_7FFF → 0xFFFF8001; LHU → 0x00008001.
- Stall/flush: stall 3 cycles mid-load → _mem/_wb outputs frozen, dmem_en=0; flush_ex with RegWrite_ex=1 → RegWrite_mem=0 next cycle, bubble reaches WB.
- MEM_MISALIGN_TRAP_EN: SW to 0x102 → dmem_be=0, misalign_err pulse in WB, RegWrite_wb=0. Without the macro → be=1111 at 0x100.
